uart_tx_queue: RTL and testbench

//  Byte FIFO plus launch sequencer directly upstream of the UART transmitter.

---
 rtl/uart_tx_queue.sv | 158 +++++++++++++++
 tb/tb_uart_tx_queue.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter one frame at a time.
// Optional START watchdog is built only when TXQ_TIMEOUT_EN is defined.
module uart_tx_queue #(
  parameter int DATA_W        = 8,
  parameter int DEPTH         = 16,
  parameter int CNT_W         = 5,
  parameter int START_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_rx_start,
  input  logic              busy,
  output logic [CNT_W-1:0]  level,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic              timeout
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              wr_ready_q, wr_ready_d;
  logic              overflow_q, overflow_d;
  logic              start_q, start_d;
  logic              timeout_q, timeout_d;
  logic              push, pop, tmo_hit;

  assign push = wr_valid && wr_ready_q;
  assign pop  = (state_q == IDLE) && (level_q != '0);

`ifdef TXQ_TIMEOUT_EN
  localparam int TW = $clog2(START_TIMEOUT) + 1;

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q == START) && !busy && (tmo_cnt_q == TW'(START_TIMEOUT - 1));

  // Held at zero outside START, so every entry into START counts from zero.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != START) begin
      tmo_cnt_d = '0;
    end else if (!busy) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    tx_data_d  = tx_data_q;
    timeout_d  = 1'b0;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q;
    if (push && !pop) begin
      level_d = level_q + CNT_W'(1);
    end else if (!push && pop) begin
      level_d = level_q - CNT_W'(1);
    end
    wr_ready_d = (level_d != CNT_W'(DEPTH));
    overflow_d = overflow_q;
    if (wr_valid && !wr_ready_q) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = LOAD;
        end
      end
      LOAD: begin
        start_d = 1'b1;
        state_d = START;
      end
      START: begin
        if (busy) begin
          start_d = 1'b0;
          state_d = WAIT_DONE;
        end else if (tmo_hit) begin
          start_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tx_data_q  <= '0;
      wr_ready_q <= 1'b1;
      overflow_q <= 1'b0;
      start_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tx_data_q  <= tx_data_d;
      wr_ready_q <= wr_ready_d;
      overflow_q <= overflow_d;
      start_q    <= start_d;
      timeout_q  <= timeout_d;
    end
  end

  assign wr_ready    = wr_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_rx_start = start_q;
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a small UART busy model.
`timescale 1ns/1ps
module tb_uart_tx_queue;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;
  localparam int FRAME  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_rx_start;
  logic              busy = 1'b0;
  logic [CNT_W-1:0]  level;
  logic              overflow;
  logic              clr_ovf;
  logic              timeout;

  int checks = 0;
  int errors = 0;

  bit          uart_auto  = 1'b0;
  logic        busy_force = 1'b0;
  int          busy_left  = 0;
  int          viol       = 0;
  logic [7:0]  sent [$];

  uart_tx_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .START_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .tx_data(tx_data), .tx_rx_start(tx_rx_start), .busy(busy), .level(level),
    .overflow(overflow), .clr_ovf(clr_ovf), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // UART model: in auto mode a start raises busy for FRAME cycles and logs the byte.
  always @(posedge clk) begin
    #2;
    if (uart_auto && tx_rx_start && busy) viol++;
    if (!uart_auto) begin
      busy      = busy_force;
      busy_left = 0;
    end else if (busy_left != 0) begin
      busy_left--;
      if (busy_left == 0) busy = 1'b0;
    end else if (tx_rx_start && !busy) begin
      busy      = 1'b1;
      busy_left = FRAME;
      sent.push_back(tx_data);
    end else begin
      busy = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by 100us");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; clr_ovf = 1'b0;
    uart_auto = 1'b0; busy_force = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks += 3;
      if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready cyc %0d: got %b want 1", i, wr_ready); end
      if (level !== 5'd0) begin errors++; $display("FAIL reset_level cyc %0d: got %0d want 0", i, level); end
      if (tx_rx_start !== 1'b0) begin errors++; $display("FAIL reset_start cyc %0d: got %b want 0", i, tx_rx_start); end
    end
    checks += 3;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
  endtask

  task automatic test_single();
    int n;
    uart_auto = 1'b1; sent.delete();
    wr_data = 8'h45; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    checks += 2;
    if (level !== 5'd1) begin errors++; $display("FAIL single_level_push: got %0d want 1", level); end
    if (tx_rx_start !== 1'b0) begin errors++; $display("FAIL single_start_e0: got %b want 0", tx_rx_start); end
    tick();
    checks += 3;
    if (tx_data !== 8'h45) begin errors++; $display("FAIL single_tx_data_load: got %h want 45", tx_data); end
    if (level !== 5'd0) begin errors++; $display("FAIL single_level_pop: got %0d want 0", level); end
    if (tx_rx_start !== 1'b0) begin errors++; $display("FAIL single_start_e1: got %b want 0", tx_rx_start); end
    tick();
    checks += 2;
    if (tx_rx_start !== 1'b1) begin errors++; $display("FAIL single_start_e2: got %b want 1", tx_rx_start); end
    if (tx_data !== 8'h45) begin errors++; $display("FAIL single_tx_data_e2: got %h want 45", tx_data); end
    tick();
    checks += 1;
    if (tx_rx_start !== 1'b0) begin errors++; $display("FAIL single_start_drop: got %b want 0", tx_rx_start); end
    for (n = 0; n < 100 && !(sent.size() == 1 && busy == 1'b0); n++) tick();
    tick(); tick();
    checks += 3;
    if (sent.size() != 1) begin errors++; $display("FAIL single_frames: got %0d want 1", sent.size()); end
    else if (sent[0] !== 8'h45) begin errors++; $display("FAIL single_byte: got %h want 45", sent[0]); end
    if (level !== 5'd0) begin errors++; $display("FAIL single_level_end: got %0d want 0", level); end
    if (tx_rx_start !== 1'b0) begin errors++; $display("FAIL single_start_end: got %b want 0", tx_rx_start); end
  endtask

  task automatic test_burst();
    int n;
    logic [7:0] exp_b [6] = '{8'hEE, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    uart_auto = 1'b1; sent.delete(); viol = 0;
    wr_data = 8'hEE; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    for (n = 0; n < 20 && !(busy == 1'b1 && tx_rx_start == 1'b0); n++) tick();
    checks += 1;
    if (busy !== 1'b1) begin errors++; $display("FAIL burst_lead_busy: got %b want 1", busy); end
    for (int i = 1; i <= 5; i++) begin
      wr_data = 8'(i); wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    checks += 1;
    if (level !== 5'd5) begin errors++; $display("FAIL burst_level5: got %0d want 5", level); end
    for (n = 0; n < 40 && level == 5'd5; n++) tick();
    checks += 1;
    if (level !== 5'd4) begin errors++; $display("FAIL burst_level4: got %0d want 4", level); end
    for (n = 0; n < 300 && !(sent.size() == 6 && busy == 1'b0); n++) tick();
    tick(); tick();
    checks += 3;
    if (sent.size() != 6) begin errors++; $display("FAIL burst_frames: got %0d want 6", sent.size()); end
    else begin
      for (int i = 0; i < 6; i++)
        if (sent[i] !== exp_b[i]) begin errors++; $display("FAIL burst_order[%0d]: got %h want %h", i, sent[i], exp_b[i]); end
    end
    if (viol != 0) begin errors++; $display("FAIL burst_start_while_busy: got %0d want 0", viol); end
    if (level !== 5'd0) begin errors++; $display("FAIL burst_level_end: got %0d want 0", level); end
  endtask

  task automatic test_full();
    int n;
    uart_auto = 1'b0; busy_force = 1'b1; sent.delete();
    tick();
    wr_data = 8'h80; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick(); tick(); tick();
    checks += 2;
    if (level !== 5'd0) begin errors++; $display("FAIL full_lead_level: got %0d want 0", level); end
    if (tx_rx_start !== 1'b0) begin errors++; $display("FAIL full_lead_start: got %b want 0", tx_rx_start); end
    for (int i = 0; i < 17; i++) begin
      wr_data = 8'h10 + 8'(i); wr_valid = 1'b1;
      tick();
      if (i == 14) begin
        checks += 1;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_ready_at15: got %b want 1", wr_ready); end
      end
      if (i == 15) begin
        checks += 3;
        if (level !== 5'd16) begin errors++; $display("FAIL full_level16: got %0d want 16", level); end
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready_at16: got %b want 0", wr_ready); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_early: got %b want 0", overflow); end
      end
    end
    checks += 2;
    if (level !== 5'd16) begin errors++; $display("FAIL full_level_after17: got %0d want 16", level); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL full_ovf_set: got %b want 1", overflow); end
    wr_data = 8'h99; clr_ovf = 1'b1;
    tick();
    wr_valid = 1'b0;
    checks += 1;
    if (overflow !== 1'b1) begin errors++; $display("FAIL full_ovf_set_priority: got %b want 1", overflow); end
    tick();
    clr_ovf = 1'b0;
    checks += 1;
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_clear: got %b want 0", overflow); end
    uart_auto = 1'b1;
    for (n = 0; n < 500 && !(sent.size() == 16 && busy == 1'b0); n++) tick();
    tick(); tick();
    checks += 2;
    if (sent.size() != 16) begin errors++; $display("FAIL full_frames: got %0d want 16", sent.size()); end
    else begin
      for (int i = 0; i < 16; i++)
        if (sent[i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL full_order[%0d]: got %h want %h", i, sent[i], 8'h10 + 8'(i)); end
    end
    if (level !== 5'd0) begin errors++; $display("FAIL full_level_end: got %0d want 0", level); end
  endtask

  task automatic test_simultaneous();
    int n;
    logic [7:0] exp_s [4] = '{8'h31, 8'h32, 8'h33, 8'h34};
    uart_auto = 1'b0; busy_force = 1'b1; sent.delete();
    tick();
    wr_data = 8'h30; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick(); tick(); tick();
    for (int i = 1; i <= 3; i++) begin
      wr_data = 8'h30 + 8'(i); wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    busy_force = 1'b0;
    checks += 1;
    if (level !== 5'd3) begin errors++; $display("FAIL simul_level_pre: got %0d want 3", level); end
    tick();
    checks += 1;
    if (level !== 5'd3) begin errors++; $display("FAIL simul_level_idle: got %0d want 3", level); end
    wr_data = 8'h34; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    uart_auto = 1'b1;
    checks += 2;
    if (level !== 5'd3) begin errors++; $display("FAIL simul_level_pushpop: got %0d want 3", level); end
    if (tx_data !== 8'h31) begin errors++; $display("FAIL simul_tx_data: got %h want 31", tx_data); end
    for (n = 0; n < 300 && !(sent.size() == 4 && busy == 1'b0); n++) tick();
    tick(); tick();
    checks += 2;
    if (sent.size() != 4) begin errors++; $display("FAIL simul_frames: got %0d want 4", sent.size()); end
    else begin
      for (int i = 0; i < 4; i++)
        if (sent[i] !== exp_s[i]) begin errors++; $display("FAIL simul_order[%0d]: got %h want %h", i, sent[i], exp_s[i]); end
    end
    if (level !== 5'd0) begin errors++; $display("FAIL simul_level_end: got %0d want 0", level); end
  endtask

`ifdef TXQ_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    uart_auto = 1'b0; busy_force = 1'b0;
    tick();
    wr_data = 8'hA5; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    for (n = 0; n < 10 && tx_rx_start !== 1'b1; n++) tick();
    checks += 1;
    if (tx_rx_start !== 1'b1) begin errors++; $display("FAIL tmo_start: got %b want 1", tx_rx_start); end
    for (n = 0; n < 100 && timeout !== 1'b1; n++) tick();
    checks += 3;
    if (n != 64) begin errors++; $display("FAIL tmo_cycles: got %0d want 64", n); end
    if (tx_rx_start !== 1'b0) begin errors++; $display("FAIL tmo_start_drop: got %b want 0", tx_rx_start); end
    if (level !== 5'd0) begin errors++; $display("FAIL tmo_level: got %0d want 0", level); end
    tick();
    checks += 1;
    if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width: got %b want 0", timeout); end
  endtask
`else
  task automatic test_no_timeout();
    int n;
    bit seen;
    uart_auto = 1'b0; busy_force = 1'b0; seen = 1'b0;
    tick();
    wr_data = 8'hA5; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    for (n = 0; n < 10 && tx_rx_start !== 1'b1; n++) tick();
    for (int i = 0; i < 80; i++) begin
      tick();
      if (timeout !== 1'b0) seen = 1'b1;
    end
    checks += 2;
    if (seen) begin errors++; $display("FAIL notmo_pulse: got 1 want 0"); end
    if (tx_rx_start !== 1'b1) begin errors++; $display("FAIL notmo_start_held: got %b want 1", tx_rx_start); end
    busy_force = 1'b1;
    tick(); tick();
    busy_force = 1'b0;
    tick(); tick(); tick();
    checks += 1;
    if (tx_rx_start !== 1'b0) begin errors++; $display("FAIL notmo_release: got %b want 0", tx_rx_start); end
  endtask
`endif

  task automatic test_reset_midframe();
    uart_auto = 1'b0; busy_force = 1'b0;
    tick();
    wr_data = 8'hC1; wr_valid = 1'b1;
    tick();
    wr_data = 8'hC2;
    tick();
    wr_valid = 1'b0;
    tick(); tick(); tick();
    checks += 2;
    if (tx_rx_start !== 1'b1) begin errors++; $display("FAIL mid_start_pre: got %b want 1", tx_rx_start); end
    if (level !== 5'd1) begin errors++; $display("FAIL mid_level_pre: got %0d want 1", level); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 4;
    if (level !== 5'd0) begin errors++; $display("FAIL mid_level_rst: got %0d want 0", level); end
    if (tx_rx_start !== 1'b0) begin errors++; $display("FAIL mid_start_rst: got %b want 0", tx_rx_start); end
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_rst: got %b want 1", wr_ready); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data_rst: got %h want 00", tx_data); end
    tick(); tick();
    checks += 2;
    if (level !== 5'd0) begin errors++; $display("FAIL mid_level_after: got %0d want 0", level); end
    if (tx_rx_start !== 1'b0) begin errors++; $display("FAIL mid_start_after: got %b want 0", tx_rx_start); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_simultaneous();
`ifdef TXQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
